// File: rtl/nmemory_pkg.sv
// Shared types and default geometry for the multi-port register memory.
package nmemory_pkg;

    localparam int unsigned DATA_W_DEF = 16;
    localparam int unsigned ADDR_W_DEF = 5;
    localparam int unsigned NUM_RD_DEF = 2;

    // Post-reset sweep, then normal operation until the next reset
    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } state_e;

endpackage

// File: rtl/nmemory_mp_if.sv
// Write/read request bus of the multi-port memory; read buses are flattened per port.
interface nmemory_mp_if
    import nmemory_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned NUM_RD = NUM_RD_DEF
);

    logic                       write_enable;
    logic [ADDR_W-1:0]          write_addr;
    logic [DATA_W-1:0]          write_data;
    logic [NUM_RD-1:0]          read_enable;
    logic [NUM_RD*ADDR_W-1:0]   read_addr;
    logic [NUM_RD*DATA_W-1:0]   read_data;
    logic [NUM_RD-1:0]          read_valid;
    logic                       busy;

    modport master (
        output write_enable, write_addr, write_data, read_enable, read_addr,
        input  read_data, read_valid, busy
    );

    modport slave (
        input  write_enable, write_addr, write_data, read_enable, read_addr,
        output read_data, read_valid, busy
    );

endinterface

// File: rtl/nmemory_rd_port.sv
// One read port: registered data/valid with same-address write forwarding.
module nmemory_rd_port
    import nmemory_pkg::*;
#(
    parameter int unsigned DATA_W      = DATA_W_DEF,
    parameter int unsigned ADDR_W      = ADDR_W_DEF,
    parameter bit          WRITE_FIRST = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    input  logic [DATA_W-1:0] mem_word_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [DATA_W-1:0] wr_data_i,
    output logic [DATA_W-1:0] rd_data_o,
    output logic              rd_valid_o
);

    logic [DATA_W-1:0] rd_data_q, rd_data_d;
    logic              rd_valid_q;
    logic              fwd_c;

    // Array still holds the old word this cycle; forwarding gives write-first behaviour
    always_comb begin
        fwd_c     = WRITE_FIRST && wr_en_i && (wr_addr_i == rd_addr_i);
        rd_data_d = fwd_c ? wr_data_i : mem_word_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= rd_en_i;
            if (rd_en_i) begin
                rd_data_q <= rd_data_d;
            end
        end
    end

    assign rd_data_o  = rd_data_q;
    assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/nmemory_mp.sv
// Parametrised multi-read-port register memory with a post-reset clear sweep.
module nmemory_mp
    import nmemory_pkg::*;
#(
    parameter int unsigned        DATA_W      = DATA_W_DEF,
    parameter int unsigned        ADDR_W      = ADDR_W_DEF,
    parameter int unsigned        NUM_RD      = NUM_RD_DEF,
    parameter bit                 WRITE_FIRST = 1'b1,
    parameter logic [DATA_W-1:0]  CLEAR_VALUE = '0
) (
    input  logic       clk,
    input  logic       rst,
    nmemory_mp_if.slave bus
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              busy_q, busy_d;

    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_waddr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic              user_wr_c;
    logic              rd_ok_c;

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [NUM_RD-1:0][DATA_W-1:0] rd_data_w;
    logic [NUM_RD-1:0]             rd_valid_w;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_ptr_q <= '0;
            busy_q    <= 1'b1;
        end else begin
            state_q   <= state_d;
            clr_ptr_q <= clr_ptr_d;
            busy_q    <= busy_d;
        end
    end

    // Sweep owns the single array write port until the last word is cleared
    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        busy_d      = busy_q;
        mem_we_c    = 1'b0;
        mem_waddr_c = bus.write_addr;
        mem_wdata_c = bus.write_data;
        user_wr_c   = 1'b0;
        rd_ok_c     = 1'b0;
        unique case (state_q)
            ST_CLEAR: begin
                mem_we_c    = 1'b1;
                mem_waddr_c = clr_ptr_q;
                mem_wdata_c = CLEAR_VALUE;
                clr_ptr_d   = clr_ptr_q + ADDR_W'(1);
                if (clr_ptr_q == ADDR_W'(DEPTH - 1)) begin
                    state_d = ST_READY;
                    busy_d  = 1'b0;
                end
            end
            ST_READY: begin
                user_wr_c = bus.write_enable;
                mem_we_c  = bus.write_enable;
                rd_ok_c   = 1'b1;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    // Array is left untouched in a reset cycle; the following sweep clears it
    always_ff @(posedge clk) begin
        if (!rst && mem_we_c) begin
            mem_q[mem_waddr_c] <= mem_wdata_c;
        end
    end

    for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
        logic [ADDR_W-1:0] addr_c;
        assign addr_c = bus.read_addr[p*ADDR_W +: ADDR_W];

        nmemory_rd_port #(
            .DATA_W      (DATA_W),
            .ADDR_W      (ADDR_W),
            .WRITE_FIRST (WRITE_FIRST)
        ) u_port (
            .clk        (clk),
            .rst        (rst),
            .rd_en_i    (bus.read_enable[p] & rd_ok_c),
            .rd_addr_i  (addr_c),
            .mem_word_i (mem_q[addr_c]),
            .wr_en_i    (user_wr_c),
            .wr_addr_i  (bus.write_addr),
            .wr_data_i  (bus.write_data),
            .rd_data_o  (rd_data_w[p]),
            .rd_valid_o (rd_valid_w[p])
        );
    end

    assign bus.read_data  = rd_data_w;
    assign bus.read_valid = rd_valid_w;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_nmemory_mp.sv
// Directed bench for nmemory_mp: write-first and read-first builds driven in lockstep.
module tb_nmemory_mp;

    logic clk;
    logic rst;
    int   checks   = 0;
    int   failures = 0;

    nmemory_mp_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(2)) ifw ();
    nmemory_mp_if #(.DATA_W(16), .ADDR_W(5), .NUM_RD(2)) ifr ();

    nmemory_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(2), .WRITE_FIRST(1'b1), .CLEAR_VALUE(16'h0000))
        dut_wf (.clk(clk), .rst(rst), .bus(ifw.slave));
    nmemory_mp #(.DATA_W(16), .ADDR_W(5), .NUM_RD(2), .WRITE_FIRST(1'b0), .CLEAR_VALUE(16'h0000))
        dut_rf (.clk(clk), .rst(rst), .bus(ifr.slave));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic we, input logic [4:0] wa, input logic [15:0] wd,
                         input logic [1:0] re, input logic [4:0] ra0, input logic [4:0] ra1);
        ifw.write_enable = we;  ifr.write_enable = we;
        ifw.write_addr   = wa;  ifr.write_addr   = wa;
        ifw.write_data   = wd;  ifr.write_data   = wd;
        ifw.read_enable  = re;  ifr.read_enable  = re;
        ifw.read_addr    = {ra1, ra0};
        ifr.read_addr    = {ra1, ra0};
    endtask

    task automatic idle();
        drive(1'b0, 5'd0, 16'h0000, 2'b00, 5'd0, 5'd0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Pulse reset, check the reset state, then count busy samples over a bounded window
    task automatic reset_sweep(input bit with_req, output int cw, output int cr, output bit saw_valid);
        rst = 1'b1;
        idle();
        tick();
        chk("rst_busy",  {62'd0, ifw.busy, ifr.busy}, 64'd3);
        chk("rst_valid", {60'd0, ifw.read_valid, ifr.read_valid}, 64'd0);
        chk("rst_data",  {ifw.read_data, ifr.read_data}, 64'd0);
        rst = 1'b0;
        cw = int'(ifw.busy);
        cr = int'(ifr.busy);
        saw_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (with_req && ifw.busy) drive(1'b1, 5'd2, 16'hFFFF, 2'b11, 5'd2, 5'd2);
            else idle();
            tick();
            cw += int'(ifw.busy);
            cr += int'(ifr.busy);
            if (ifw.read_valid != 2'b00 || ifr.read_valid != 2'b00) saw_valid = 1'b1;
        end
        idle();
    endtask

    initial begin
        int  cw, cr;
        bit  saw;
        bit  mid_busy;

        rst = 1'b0;
        idle();

        // Initial sweep with requests issued while busy
        reset_sweep(1'b1, cw, cr, saw);
        chk("sweep_len_wf", 64'(cw), 64'd32);
        chk("sweep_len_rf", 64'(cr), 64'd32);
        chk("busy_req_valid", {63'd0, saw}, 64'd0);
        chk("busy_low", {62'd0, ifw.busy, ifr.busy}, 64'd0);

        // Every location cleared; port0 ascends, port1 descends
        for (int a = 0; a < 32; a++) begin
            drive(1'b0, 5'd0, 16'h0000, 2'b11, 5'(a), 5'(31 - a));
            tick();
            chk($sformatf("clr_rd_wf_%0d", a), {30'd0, ifw.read_valid, ifw.read_data}, {30'd0, 2'b11, 32'h0});
            chk($sformatf("clr_rd_rf_%0d", a), {30'd0, ifr.read_valid, ifr.read_data}, {30'd0, 2'b11, 32'h0});
        end
        idle();
        tick();
        chk("valid_drop", {60'd0, ifw.read_valid, ifr.read_valid}, 64'd0);

        // Write then read one cycle later
        drive(1'b1, 5'd7, 16'hBEEF, 2'b00, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 16'h0000, 2'b01, 5'd7, 5'd0);
        tick();
        chk("wr_rd_data", {32'd0, ifw.read_data[15:0], ifr.read_data[15:0]}, {32'd0, 16'hBEEF, 16'hBEEF});
        chk("wr_rd_valid", {60'd0, ifw.read_valid, ifr.read_valid}, {60'd0, 2'b01, 2'b01});
        idle();
        tick();
        chk("hold_valid", {60'd0, ifw.read_valid, ifr.read_valid}, 64'd0);
        chk("hold_data", {32'd0, ifw.read_data[15:0], ifr.read_data[15:0]}, {32'd0, 16'hBEEF, 16'hBEEF});

        // Read-during-write on port1, same address
        drive(1'b1, 5'd3, 16'h1111, 2'b00, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd3, 16'h2222, 2'b10, 5'd0, 5'd3);
        tick();
        chk("rdw_wf", {47'd0, ifw.read_valid[1], ifw.read_data[31:16]}, {47'd0, 1'b1, 16'h2222});
        chk("rdw_rf", {47'd0, ifr.read_valid[1], ifr.read_data[31:16]}, {47'd0, 1'b1, 16'h1111});
        drive(1'b0, 5'd0, 16'h0000, 2'b10, 5'd0, 5'd3);
        tick();
        chk("rdw_next", {32'd0, ifw.read_data[31:16], ifr.read_data[31:16]}, {32'd0, 16'h2222, 16'h2222});

        // Dual-port concurrency
        drive(1'b1, 5'd4, 16'hA5A5, 2'b00, 5'd0, 5'd0);
        tick();
        drive(1'b1, 5'd9, 16'h5A5A, 2'b00, 5'd0, 5'd0);
        tick();
        drive(1'b0, 5'd0, 16'h0000, 2'b11, 5'd4, 5'd9);
        tick();
        chk("dual_wf", {32'd0, ifw.read_data}, {32'd0, 16'h5A5A, 16'hA5A5});
        chk("dual_rf", {32'd0, ifr.read_data}, {32'd0, 16'h5A5A, 16'hA5A5});
        // Both ports on addr 4 while an unrelated address is written
        drive(1'b1, 5'd10, 16'h1234, 2'b11, 5'd4, 5'd4);
        tick();
        chk("same_addr_wf", {32'd0, ifw.read_data}, {32'd0, 16'hA5A5, 16'hA5A5});
        chk("same_addr_rf", {32'd0, ifr.read_data}, {32'd0, 16'hA5A5, 16'hA5A5});
        drive(1'b0, 5'd0, 16'h0000, 2'b01, 5'd10, 5'd0);
        tick();
        chk("indep_wr", {32'd0, ifw.read_data[15:0], ifr.read_data[15:0]}, {32'd0, 16'h1234, 16'h1234});

        // Reset mid-sweep restarts the full sweep
        drive(1'b1, 5'd12, 16'h7777, 2'b00, 5'd0, 5'd0);
        tick();
        rst = 1'b1;
        idle();
        tick();
        rst = 1'b0;
        mid_busy = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (!ifw.busy || !ifr.busy) mid_busy = 1'b0;
        end
        chk("mid_busy", {63'd0, mid_busy}, 64'd1);
        reset_sweep(1'b0, cw, cr, saw);
        chk("resweep_wf", 64'(cw), 64'd32);
        chk("resweep_rf", 64'(cr), 64'd32);
        chk("resweep_valid", {63'd0, saw}, 64'd0);

        drive(1'b0, 5'd0, 16'h0000, 2'b11, 5'd12, 5'd7);
        tick();
        chk("post_clr_a", {28'd0, ifw.read_valid, ifr.read_valid, ifw.read_data},
            {28'd0, 2'b11, 2'b11, 32'h0});
        chk("post_clr_a_rf", {32'd0, ifr.read_data}, 64'd0);
        drive(1'b0, 5'd0, 16'h0000, 2'b11, 5'd2, 5'd3);
        tick();
        chk("post_clr_b", {ifw.read_data, ifr.read_data}, 64'd0);
        idle();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/nmemory_mp.md
Name: nmemory_mp

Overview:
- Parametrised successor of the single-port 16-bit register memory.
- Generalised in data width, address width and number of read ports.
- Adds a post-reset hardware clear sweep with a busy flag, a registered read-valid strobe, and configurable read-during-write policy.
- Serves as instruction or data memory in the pipelined processor. Fetch and operand/loader reads can share one array through separate read ports.

Parameters:
- DATA_W, 16, word width in bits
- ADDR_W, 5, address width; DEPTH = 1<<ADDR_W words
- NUM_RD, 2, number of independent read ports (1..4)
- WRITE_FIRST, 1, 1: a same-cycle read of the address being written returns new data; 0: returns old data
- CLEAR_VALUE, 0, word written to every location during the post-reset sweep

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- write_enable  in  1  write request
- write_addr  in  ADDR_W  write address
- write_data  in  DATA_W  write data
- read_enable  in  NUM_RD  per-port read request
- read_addr  in  NUM_RD*ADDR_W  port p occupies bits [p*ADDR_W +: ADDR_W]
- read_data  out  NUM_RD*DATA_W  port p occupies bits [p*DATA_W +: DATA_W]; registered
- read_valid  out  NUM_RD  per-port one-cycle strobe qualifying read_data
- busy  out  1  high while the clear sweep runs; all requests are ignored while high

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst; it is sampled only at rising edges.
- Reset (rst=1 at an edge):
  - state<=CLEAR, clr_ptr<=0, busy<=1.
  - read_data<=0 and read_valid<=0 for all ports.
  - Array contents are not touched in the reset cycle itself.
- Reset asserted mid-sweep or mid-operation restarts the sweep from address 0. Any write in that cycle is dropped.
- CLEAR state:
  - Each cycle: mem[clr_ptr]<=CLEAR_VALUE, clr_ptr<=clr_ptr+1.
  - On the cycle clr_ptr==DEPTH-1 is written: state<=READY, busy<=0 at that same edge.
  - busy is therefore high for exactly DEPTH cycles after rst deasserts.
  - write_enable and read_enable are ignored; read_valid stays 0 and read_data holds 0.
- READY state:
  - Write: write_enable=1 at an edge -> mem[write_addr]<=write_data. The stored value is visible to reads issued on the next cycle.
  - Read, per port p: read_enable[p]=1 at edge N -> at edge N, read_data[p]<=mem[addr_p] and read_valid[p]<=1. Latency is one cycle.
  - read_enable[p]=0 -> read_valid[p]<=0 and read_data[p] holds its last value.
  - Read-during-write, same address, same edge: WRITE_FIRST=1 -> read_data gets write_data; WRITE_FIRST=0 -> old mem contents.
  - Different addresses: read and write are independent.
  - Multiple ports may read the same address in the same cycle; each returns identical data.
  - Addresses are always in range (DEPTH = 2^ADDR_W). No wrap or error logic.
- No other states. READY persists until rst.

Decomposition:
- Shared package/include nmemory_pkg:
  - State encodings ST_CLEAR and ST_READY as localparams.
  - Port-slice helper macros for the flattened read buses.
- Natural sub-module: nmemory_rd_port.
  - Holds one port's registered read_data/read_valid and the read-during-write forwarding mux.
  - Instantiated NUM_RD times by a generate loop.
- The storage array, clear FSM and write logic stay in nmemory_mp.

Test Plan:
- Reset sweep: ADDR_W=5, pulse rst 1 cycle -> busy=1 for exactly 32 cycles then 0; afterwards reading all 32 addresses returns 0x0000, each with read_valid one cycle after its request.
- Write then read: write 0xBEEF to addr 7 at cycle T; port0 reads addr 7 at T+1 -> read_data[15:0]=0xBEEF and read_valid[0]=1 at T+2; read_valid[0]=0 at T+3 with data held at 0xBEEF.
- Read-during-write: mem[3]=0x1111; same edge write 0x2222 to addr 3 and port1 reads addr 3 -> WRITE_FIRST=1 returns 0x2222, WRITE_FIRST=0 returns 0x1111; next-cycle read returns 0x2222 in both builds.
- Dual-port concurrency: mem[4]=0xA5A5, mem[9]=0x5A5A; port0 reads 4 and port1 reads 9 in the same cycle -> both correct next cycle; both ports reading addr 4 -> both return 0xA5A5.
- Requests during busy: write 0xFFFF to addr 2 and read addr 2 while busy=1 -> read_valid stays 0; after busy falls, addr 2 reads 0x0000.
- Reset mid-sweep: assert rst at sweep cycle 10 -> busy stays 1 and remains high for a full 32 cycles after rst deasserts; all locations read 0 afterwards, including previously written ones.
